// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory; one request in flight, byte-lane stores, full-word loads.
// Latency: response raised LATENCY edges after acceptance, so the earliest handshake is at edge LATENCY+1.
// Backpressure: the response is held stable until rsp_ready; req_ready stays low until that handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_valid/ready   request handshake; req_write, req_addr, req_wdata, req_be qualify it
//   rsp_valid/ready   response handshake; rsp_rdata (0 for stores), rsp_err
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault irregular or misaligned byte
// enables (rsp_err=1, rsp_rdata=0, no write). Without it rsp_err is tied 0.
module dmem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int         NB    = DATA_WIDTH / 8;
  localparam int         DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      req_ready_q, req_ready_d;
  logic                      write_q, write_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [NB-1:0]             be_q, be_d;
  logic                      bad_q, bad_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic                      req_fire, rsp_fire, enter_resp, req_bad;
  // Access operands: live request when entering RESP straight from IDLE (LATENCY=0),
  // latched copy otherwise.
  logic                      acc_write, acc_bad;
  logic [MEM_DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_WIDTH-1:0]     acc_wdata;
  logic [NB-1:0]             acc_be;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  assign req_fire   = req_valid && req_ready_q;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic unused_addr;
  // Upper address bits alias; only the word index and the low two bits matter.
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2];

  always_comb begin
    req_bad = 1'b1;
    case (req_be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: req_bad = 1'b0;
      4'b0011, 4'b1100:                            req_bad = req_addr[0];
      4'b1111:                                     req_bad = |req_addr[1:0];
      default:                                     req_bad = 1'b1;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (enter_resp) err_d = acc_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  logic unused_addr;
  // Byte offset is meaningless without the alignment check; upper bits alias.
  assign unused_addr = ^{req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], req_addr[1:0]};
  assign req_bad     = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      bad_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      bad_q       <= bad_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire) state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_idx   = req_addr[MEM_DEPTH_LOG2+1:2];
      acc_wdata = req_wdata;
      acc_be    = req_be;
      acc_bad   = req_bad;
    end else begin
      acc_write = write_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_bad   = bad_q;
    end
  end

  // Datapath: request latch, wait counter, ready, read data.
  always_comb begin
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    bad_d       = bad_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        // Out of reset ready is 0 here and rises on the next edge.
        req_ready_d = !req_fire;
        if (req_fire) begin
          cnt_d   = LAT;
          write_d = req_write;
          idx_d   = req_addr[MEM_DEPTH_LOG2+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          bad_d   = req_bad;
        end
      end
      S_WAIT: begin
        req_ready_d = 1'b0;
        cnt_d       = cnt_q - 4'd1;
      end
      S_RESP: begin
        // Ready returns on the handshake edge, so no accept can coincide with it.
        req_ready_d = rsp_fire;
      end
      default: req_ready_d = 1'b0;
    endcase
    if (enter_resp) rdata_d = (acc_write || acc_bad) ? '0 : mem[acc_idx];
  end

  // Array write on the edge that enters RESP; a reset keeps the FSM out of that path.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_bad) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // Outputs.
  always_comb begin
    rsp_valid = (state_q == S_RESP);
    req_ready = req_ready_q;
    rsp_rdata = rdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance (u_a) and LATENCY=0 instance (u_b).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dsel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  assign a_req_valid = req_valid & ~dsel;
  assign b_req_valid = req_valid & dsel;
  assign req_ready   = dsel ? b_req_ready : a_req_ready;
  assign rsp_valid   = dsel ? b_rsp_valid : a_rsp_valid;
  assign rsp_rdata   = dsel ? b_rsp_rdata : a_rsp_rdata;
  assign rsp_err     = dsel ? b_rsp_err   : a_rsp_err;

  dmem_responder #(.LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.LATENCY(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  function automatic bit legal(input logic [3:0] be, input logic [1:0] lo);
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      4'b0011, 4'b1100: return lo[0] == 1'b0;
      4'b1111:          return lo == 2'b00;
      default:          return 1'b0;
    endcase
  endfunction
`endif

  // One transaction. first_k = edges after acceptance at which rsp_valid is first seen,
  // hs_k = edge index (acceptance = 0) of the response handshake.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int stall, input bit pulse,
                      output logic [31:0] rd, output logic er,
                      output int first_k, output int hs_k);
    int  n;
    bit  hs;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = (stall == 0);
    step();
    // Scramble request fields: the responder must use its latched copy.
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_be = ~be;
    rd = 'x; er = 1'bx; first_k = -1; hs_k = -1;
    for (int k = 0; k < 40; k++) begin
      req_valid = 1'b0;
      if (rsp_valid) begin
        if (first_k < 0) begin
          first_k = k; rd = rsp_rdata; er = rsp_err;
        end else begin
          chk("hold_rdata", rsp_rdata, rd);
          chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
          chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
          if (pulse && k == first_k + 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_be = 4'hF;
          end
        end
        if (k - first_k >= stall) rsp_ready = 1'b1;
      end
      hs = rsp_valid && rsp_ready;
      step();
      if (hs) begin hs_k = k + 1; break; end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    if (hs_k < 0) chk("rsp_timeout", 32'd0, 32'd1);
    chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vt[13];
  logic [31:0] mdl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, a, exp_rd, up;
    logic        er, w, exp_er;
    logic [3:0]  be;
    logic [1:0]  lo;
    int          fk, hk, idx, st;

    vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h20,   32'h0000AA00, 4'h2, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h1122AA44, 1'b0};
    vt[5]  = '{1'b1, 32'h20,   32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h1122AA44, 1'b0};
    vt[7]  = '{1'b0, 32'h1020, 32'h0,        4'hF, 32'h1122AA44, 1'b0};
    vt[8]  = '{1'b1, 32'h10,   32'h12345678, 4'hC, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h10,   32'h0,        4'h1, 32'h1234BEEF, 1'b0};
    vt[10] = '{1'b1, 32'h10,   32'h000000AB, 4'h1, 32'h0,        1'b0};
    vt[11] = '{1'b1, 32'h10,   32'hCD000000, 4'h8, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hCD34BEAB, 1'b0};

    rst = 1'b0; dsel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, a_req_ready}, 32'd0);
    step();
    chk("ready_first_edge", {31'd0, a_req_ready}, 32'd1);
    chk("ready_first_edge_b", {31'd0, b_req_ready}, 32'd1);

    // Directed table on the LATENCY=2 instance.
    for (int i = 0; i < 13; i++) begin
      xact(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].be, 0, 1'b0, rd, er, fk, hk);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_hs_edge", i), 32'(hk), 32'd3);
    end

    // Backpressure: 5 stall cycles with a request pulse in the middle.
    xact(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, rd, er, fk, hk);
    chk("bp_rdata", rd, 32'hCD34BEAB);
    chk("bp_first_valid", 32'(fk), 32'd2);
    chk("bp_hs_edge", 32'(hk), 32'd8);
    repeat (3) begin
      step();
      chk("bp_no_accept", {31'd0, a_rsp_valid}, 32'd0);
    end
    xact(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("bp_pulse_no_write", rd, 32'hCD34BEAB);

`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("align_load_err", {31'd0, er}, 32'd1);
    chk("align_load_rdata", rd, 32'd0);
    chk("align_load_hs_edge", 32'(hk), 32'd3);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h6, 0, 1'b0, rd, er, fk, hk);
    chk("align_store_err", {31'd0, er}, 32'd1);
    xact(1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("align_store2_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("align_mem_unchanged", rd, 32'h1122AA44);
    chk("align_ok_err", {31'd0, er}, 32'd0);
`else
    xact(1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("noalign_err", {31'd0, er}, 32'd0);
    chk("noalign_rdata", rd, 32'h1122AA44);
`endif

    // Reset during WAIT of a store: no write, outputs cleared at once.
    xact(1'b1, 32'h30, 32'h600DCAFE, 4'hF, 0, 1'b0, rd, er, fk, hk);
    xact(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("pre_rst_load", rd, 32'h600DCAFE);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    req_be = 4'hF; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("mid_rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b0;
    step();
    xact(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("post_rst_old_data", rd, 32'h600DCAFE);

    // Randomized traffic against a word-array model (region 0x100..0x13F).
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      xact(1'b1, 32'h100 + 32'(i * 4), wd, 4'hF, 0, 1'b0, rd, er, fk, hk);
      mdl[i] = wd;
      chk("rnd_init_rdata", rd, 32'd0);
    end
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 15);
      lo  = 2'($urandom_range(0, 3));
      up  = $urandom;
      a   = {up[19:0], 10'(64 + idx), lo};
      w   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      be  = 4'($urandom_range(0, 15));
      st  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      exp_er = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      exp_er = !legal(be, lo);
`endif
      if (exp_er) exp_rd = 32'd0;
      else if (w) begin
        exp_rd = 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end else exp_rd = mdl[idx];
      xact(w, a, wd, be, st, 1'b0, rd, er, fk, hk);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, exp_er});
      chk($sformatf("rnd%0d_first", n), 32'(fk), 32'd2);
      chk($sformatf("rnd%0d_hs", n), 32'(hk), 32'(fk + st + 1));
    end

    // LATENCY=0 instance: aliasing across 4 KiB.
    dsel = 1'b1;
    xact(1'b1, 32'h1000, 32'h5, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("lat0_store_rdata", rd, 32'd0);
    chk("lat0_store_first", 32'(fk), 32'd0);
    chk("lat0_store_hs", 32'(hk), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("lat0_alias_rdata", rd, 32'h5);
    chk("lat0_load_hs", 32'(hk), 32'd1);
    xact(1'b1, 32'h2004, 32'hA5A5A5A5, 4'h3, 0, 1'b0, rd, er, fk, hk);
    xact(1'b1, 32'h0004, 32'h5A5A5A5A, 4'hC, 0, 1'b0, rd, er, fk, hk);
    xact(1'b0, 32'h3004, 32'h0, 4'hF, 0, 1'b0, rd, er, fk, hk);
    chk("lat0_lanes_rdata", rd, 32'h5A5AA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
